// File: rtl/i2c_byte_arbiter.sv
// Round-robin arbiter sharing one single-byte I2C master between N_REQ requesters.
// Latches the winner's request, issues one start, waits with a watchdog, returns the result.
module i2c_byte_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TIMEOUT_CYC = 32768
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [7*N_REQ-1:0] req_addr,
  input  logic [N_REQ-1:0]   req_rw,
  input  logic [8*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               err,
  output logic               timeout,
  output logic [7:0]         rdata,
  output logic               m_start,
  output logic [6:0]         m_addr,
  output logic               m_rw,
  output logic [7:0]         m_wdata,
  output logic               m_abort,
  input  logic               m_busy,
  input  logic               m_done,
  input  logic               m_nack,
  input  logic [7:0]         m_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  localparam int unsigned IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   gidx;
  logic [CNT_W-1:0]   wd;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  logic               grant_go;
  logic               take_done;
  logic               expire;

  // First pending requester at or above the pointer, wrapping to 0.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cand = IDX_W'((32'(ptr) + off) % N_REQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Expiry is detected one count early so the abort lands TIMEOUT_CYC cycles after m_start.
  always_comb begin
    state_nxt = state;
    grant_go  = 1'b0;
    take_done = 1'b0;
    expire    = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_valid && !m_busy) begin
          grant_go  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (m_done) begin
          take_done = 1'b1;
          state_nxt = DONE;
        end else if (wd == CNT_W'(TIMEOUT_CYC - 2)) begin
          expire    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr     <= '0;
      gidx    <= '0;
      wd      <= '0;
      gnt     <= '0;
      done    <= '0;
      err     <= 1'b0;
      timeout <= 1'b0;
      rdata   <= '0;
      m_start <= 1'b0;
      m_addr  <= '0;
      m_rw    <= 1'b0;
      m_wdata <= '0;
      m_abort <= 1'b0;
    end else begin
      m_start <= grant_go;
      m_abort <= expire;
      done    <= '0;

      if (grant_go) begin
        gnt     <= N_REQ'(1) << pick_idx;
        gidx    <= pick_idx;
        m_addr  <= req_addr[32'(pick_idx) * 7 +: 7];
        m_rw    <= req_rw[pick_idx];
        m_wdata <= req_wdata[32'(pick_idx) * 8 +: 8];
      end

      if (state == ISSUE)     wd <= '0;
      else if (state == WAIT) wd <= wd + 1'b1;

      if (take_done) begin
        rdata   <= m_rdata;
        err     <= m_nack;
        timeout <= 1'b0;
        done    <= gnt;
      end

      if (expire) begin
        err     <= 1'b1;
        timeout <= 1'b1;
        done    <= gnt;
      end

      if (state == DONE) begin
        gnt <= '0;
        ptr <= (gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_byte_arbiter.sv
// Directed bench for i2c_byte_arbiter: one instance at the default watchdog,
// one with TIMEOUT_CYC=64 for expiry and tie cases.
module tb_i2c_byte_arbiter;

  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, req_t;
  logic [7*N-1:0] req_addr;
  logic [N-1:0]   req_rw;
  logic [8*N-1:0] req_wdata;
  logic           m_busy, m_done, m_nack, m_done_t, m_nack_t;
  logic [7:0]     m_rdata;

  logic [N-1:0] gnt, done, gnt_t, done_t;
  logic         err, timeout, m_start, m_rw, m_abort;
  logic         err_t, timeout_t, m_start_t, m_rw_t, m_abort_t;
  logic [7:0]   rdata, m_wdata, rdata_t, m_wdata_t;
  logic [6:0]   m_addr, m_addr_t;

  int n_chk = 0;
  int n_err = 0;
  int abort_cnt = 0;
  int abort_cnt_t = 0;
  int start_cnt = 0;

  i2c_byte_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .timeout(timeout),
    .rdata(rdata), .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw),
    .m_wdata(m_wdata), .m_abort(m_abort), .m_busy(m_busy), .m_done(m_done),
    .m_nack(m_nack), .m_rdata(m_rdata)
  );

  i2c_byte_arbiter #(.N_REQ(N), .TIMEOUT_CYC(64)) dut_t (
    .clk(clk), .rst(rst), .req(req_t), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt_t), .done(done_t), .err(err_t),
    .timeout(timeout_t), .rdata(rdata_t), .m_start(m_start_t), .m_addr(m_addr_t),
    .m_rw(m_rw_t), .m_wdata(m_wdata_t), .m_abort(m_abort_t), .m_busy(1'b0),
    .m_done(m_done_t), .m_nack(m_nack_t), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_abort)   abort_cnt++;
    if (m_abort_t) abort_cnt_t++;
    if (m_start)   start_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_start(input bit t, input string tag, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((t ? m_start_t : m_start) === 1'b1) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) chk({tag, "_start_seen"}, 0, 1);
  endtask

  task automatic serve(input bit t, input int lat, input logic nack, input logic [7:0] rd);
    repeat (lat) @(negedge clk);
    if (t) begin m_done_t = 1'b1; m_nack_t = nack; end
    else   begin m_done   = 1'b1; m_nack   = nack; end
    m_rdata = rd;
    @(negedge clk);
    m_done = 1'b0; m_done_t = 1'b0; m_nack = 1'b0; m_nack_t = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got expired, expected finish");
    $fatal(1);
  end

  initial begin
    int cyc, sc, ac, n;
    rst = 1'b0; req = '0; req_t = '0; req_rw = '0; req_wdata = '0;
    req_addr = {7'h13, 7'h12, 7'h11, 7'h10};
    m_busy = 1'b0; m_done = 1'b0; m_nack = 1'b0; m_done_t = 1'b0; m_nack_t = 1'b0;
    m_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {gnt, done, err, timeout, rdata, m_start, m_addr, m_rw, m_wdata, m_abort}, '0);
    chk("rst_outs_t", {gnt_t, done_t, err_t, timeout_t, rdata_t, m_start_t, m_addr_t,
                       m_rw_t, m_wdata_t, m_abort_t}, '0);
    rst = 1'b1;

    // Round robin, all four requesting
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_start(0, "rr", cyc);
      chk(g == 0 ? "rr_lat" : "rr_gap", cyc, g == 0 ? 1 : 2);
      chk("rr_gnt", gnt, 4'b0001 << (g % 4));
      chk("rr_addr", m_addr, 7'h10 + g % 4);
      if (g == 4) req = '0;
      serve(0, 10, 1'b0, 8'h00);
      chk("rr_done", done, 4'b0001 << (g % 4));
    end
    @(negedge clk);
    chk("rr_idle", {gnt, done}, '0);

    // Single write on requester 2, 100-cycle master latency
    req_addr[20:14] = 7'h50; req_rw[2] = 1'b0; req_wdata[23:16] = 8'hAC;
    req = 4'b0100;
    wait_start(0, "wr", cyc);
    chk("wr_lat", cyc, 1);
    chk("wr_gnt", gnt, 4'b0100);
    chk("wr_addr_data_rw", {m_addr, m_wdata, m_rw}, {7'h50, 8'hAC, 1'b0});
    req = '0; req_wdata[23:16] = 8'h00;
    @(negedge clk);
    chk("wr_start_pulse", m_start, 0);
    chk("wr_data_hold", m_wdata, 8'hAC);
    serve(0, 99, 1'b0, 8'h77);
    chk("wr_done", {done, err, timeout, m_abort}, {4'b0100, 3'b000});
    chk("wr_rdata", rdata, 8'h77);
    chk("wr_start_cnt", start_cnt, 6);

    // Read on requester 1
    req_addr[13:7] = 7'h21; req_rw[1] = 1'b1; req = 4'b0010;
    wait_start(0, "rd", cyc);
    chk("rd_gnt_rw", {gnt, m_rw, m_addr}, {4'b0010, 1'b1, 7'h21});
    req = '0;
    serve(0, 5, 1'b0, 8'h3C);
    chk("rd_done", {done, err, timeout}, {4'b0010, 2'b00});
    chk("rd_data", rdata, 8'h3C);

    // NACK on requester 0
    req_addr[6:0] = 7'h2A; req_rw[0] = 1'b0; req = 4'b0001;
    wait_start(0, "nk", cyc);
    chk("nk_gnt", gnt, 4'b0001);
    req = '0;
    serve(0, 7, 1'b1, 8'h00);
    chk("nk_done", {done, err, timeout, m_abort}, {4'b0001, 1'b1, 1'b0, 1'b0});
    chk("nk_abort_cnt", abort_cnt, 0);

    // Busy hold-off, then reset in WAIT (pointer is 1 here)
    m_busy = 1'b1; req = 4'b0010;
    sc = start_cnt;
    repeat (10) @(negedge clk);
    chk("busy_nostart", start_cnt, sc);
    chk("busy_gnt", gnt, 0);
    m_busy = 1'b0;
    wait_start(0, "bz", cyc);
    chk("bz_lat", cyc, 1);
    chk("bz_gnt", gnt, 4'b0010);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("rst_async", {gnt, done, err, timeout, rdata, m_start, m_addr, m_rw, m_wdata, m_abort}, '0);
    req = 4'b0011;
    @(negedge clk);
    rst = 1'b1;
    wait_start(0, "pr", cyc);
    chk("post_rst_gnt", gnt, 4'b0001);
    req = '0;
    serve(0, 3, 1'b0, 8'h00);
    chk("post_rst_done", done, 4'b0001);

    // Short-watchdog instance: a normal read first
    req_t = 4'b0010;
    wait_start(1, "trd", cyc);
    req_t = '0;
    serve(1, 5, 1'b0, 8'h5A);
    chk("t_rd", {done_t, err_t, timeout_t, rdata_t}, {4'b0010, 2'b00, 8'h5A});

    // Timeout: master never completes
    m_rdata = 8'hEE;
    req_t = 4'b0001;
    wait_start(1, "to", cyc);
    req_t = '0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (m_abort_t) break;
    end
    chk("to_cycles", n, 64);
    chk("to_done", {done_t, err_t, timeout_t, m_abort_t}, {4'b0001, 3'b111});
    chk("to_rdata_kept", rdata_t, 8'h5A);
    @(negedge clk);
    chk("to_abort_pulse", m_abort_t, 0);

    // m_done on the expiry cycle wins
    req_t = 4'b0001;
    wait_start(1, "tie", cyc);
    req_t = '0;
    ac = abort_cnt_t;
    serve(1, 63, 1'b0, 8'h66);
    chk("tie_done", {done_t, err_t, timeout_t, m_abort_t}, {4'b0001, 3'b000});
    chk("tie_rdata", rdata_t, 8'h66);
    @(negedge clk);
    chk("tie_abort_cnt", abort_cnt_t, ac);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_byte_arbiter.md
Name: i2c_byte_arbiter

Overview:
- Shares one `i2c_master_single_byte` engine between N_REQ on-chip requesters, one byte transaction at a time.
- Arbitration is round-robin. The block latches the winner's slave address, direction and write byte, then issues a single start pulse to the master.
- It waits for the master to complete, with a watchdog timeout, and returns completion, error and read data to the granted requester.
- Sits between the sensor/config clients and the I2C master in the capstone datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 32768, clk cycles allowed from m_start to m_done before abort (must be >= 2).
- CNT_W, $clog2(TIMEOUT_CYC), watchdog counter width (derived, do not override).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester transaction request, level
- req_addr  in  7*N_REQ  packed 7-bit slave addresses, requester i at [7i+6:7i]
- req_rw  in  N_REQ  per-requester direction, 1 = read, 0 = write
- req_wdata  in  8*N_REQ  packed write bytes, requester i at [8i+7:8i]
- gnt  out  N_REQ  one-hot grant, held for the whole transaction
- done  out  N_REQ  one-cycle completion pulse to the granted requester
- err  out  1  valid with any done bit; 1 = NACK or timeout
- timeout  out  1  valid with any done bit; 1 = watchdog expiry
- rdata  out  8  read byte, valid with done
- m_start  out  1  one-cycle start pulse to the master
- m_addr  out  7  slave address to the master
- m_rw  out  1  direction to the master
- m_wdata  out  8  write byte to the master
- m_abort  out  1  one-cycle abort pulse to the master on timeout
- m_busy  in  1  master busy
- m_done  in  1  master completion pulse
- m_nack  in  1  master NACK flag, valid with m_done
- m_rdata  in  8  master read byte, valid with m_done

Behaviour:
- Reset (rst low, async):
  - state = IDLE, round-robin pointer = 0, watchdog count = 0.
  - All outputs 0, including gnt, done, err, timeout, rdata, m_*.
  - No m_abort is issued on reset, because the master shares the same rst.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If (|req) and !m_busy: select the first i with req[i]=1, searching from the pointer upward and wrapping past N_REQ-1 to 0.
  - Register gnt = one-hot(i), m_addr = req_addr[i], m_rw = req_rw[i], m_wdata = req_wdata[i]; go to ISSUE.
  - If m_busy is high: stay in IDLE, no grant.
- ISSUE:
  - m_start = 1 for exactly this one cycle; clear the watchdog; go to WAIT.
  - Latency: req sampled at edge k gives gnt and m_start high from edge k+1.
- WAIT:
  - Watchdog increments each cycle.
  - On m_done: rdata = m_rdata (write transactions also capture it, with content don't-care), err = m_nack, timeout = 0; go to DONE.
  - If the count reaches TIMEOUT_CYC-1 without m_done: m_abort = 1 for one cycle, err = 1, timeout = 1, rdata unchanged; go to DONE.
  - If m_done and expiry fall in the same cycle, m_done wins and there is no abort.
- DONE:
  - done[i] = 1 for one cycle; err, timeout and rdata are held valid that cycle.
  - Pointer becomes (i+1) mod N_REQ; gnt clears on the next edge; go to IDLE.
- m_addr, m_rw and m_wdata are stable from ISSUE through DONE. They hold their last values in IDLE until the next grant.
- Dropping req after the grant does not cancel the transaction; it completes and done still pulses.
- A requester that keeps req high after done is re-arbitrated. With rotation, every other pending requester is served before it.
- Minimum back-to-back spacing is done at edge n, then the next m_start at edge n+2.
- Changes to req_* inputs while granted are ignored.
- Reset mid-transaction forces the reset values immediately, and the next arbitration starts at requester 0.

Test Plan:
- Single write: req[2]=1, req_addr[2]=0x50, rw=0, wdata=0xAC.
  - gnt=4'b0100 and a single m_start pulse one cycle later, with m_addr=0x50, m_wdata=0xAC.
  - Model asserts m_done 100 cycles later with m_nack=0, giving a done[2] pulse with err=0 and timeout=0.
- Round robin: req=4'b1111 held, model completes each transfer after 10 cycles.
  - Grant order is 0,1,2,3,0 and no requester is granted twice in a row.
- Read: req[1] with rw=1, model returns m_rdata=0x3C with m_done.
  - rdata=0x3C and err=0 in the done[1] cycle.
- NACK: model asserts m_done with m_nack=1.
  - done pulse with err=1, timeout=0, and no m_abort.
- Timeout with TIMEOUT_CYC=64: model never asserts m_done.
  - m_abort pulse 64 cycles after m_start, then done with err=1 and timeout=1.
  - Repeat with m_done on the expiry cycle: no abort, timeout=0.
- Busy and reset: m_busy held high with req=4'b0010 gives no m_start until m_busy drops.
  - Asserting rst low in WAIT clears all outputs asynchronously.
  - After release with req=4'b0011, requester 0 is granted first.
